// File: rtl/fetch_pkg.sv
// Shared types and constants for the IF -> ID prefetch path.
// Each queue entry is a {pc, instr} pair that is never split.
package fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 32;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // ID substitutes this word whenever out_valid is low.
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/fetch_queue_if.sv
// IF/ID hand-off bundle for the fetch queue.
// Both sides use valid/ready: a transfer happens on a rising edge where valid and ready are both high and flush is low.
interface fetch_queue_if #(
    parameter int AW = 2
);
    import fetch_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [PC_W-1:0]    in_pc;
    logic [INSTR_W-1:0] in_instr;
    logic               flush;
    logic               out_valid;
    logic               out_ready;
    logic [PC_W-1:0]    out_pc;
    logic [INSTR_W-1:0] out_instr;
    logic [AW:0]        count;

    modport master (
        output in_valid, in_pc, in_instr, flush, out_ready,
        input  in_ready, out_valid, out_pc, out_instr, count
    );

    modport slave (
        input  in_valid, in_pc, in_instr, flush, out_ready,
        output in_ready, out_valid, out_pc, out_instr, count
    );

endinterface

// File: rtl/fetch_queue.sv
// Prefetch FIFO between IF and ID: holds up to DEPTH {pc, instr} pairs, with a
// single-cycle flush for wrong-path discard. Outputs depend only on registered state.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          CLK,
    input  logic          RST_N,
    fetch_queue_if.slave  fq
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    fetch_entry_t    storage [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            push;
    logic            pop;
    fetch_entry_t    head;

    // in_ready comes from count alone, so a pop cannot free a slot in the same cycle.
    assign fq.in_ready  = (count != FULL_CNT);
    assign fq.out_valid = (count != '0);
    assign push         = fq.in_valid  & fq.in_ready  & ~fq.flush;
    assign pop          = fq.out_valid & fq.out_ready & ~fq.flush;

    assign head         = storage[rd_ptr];
    assign fq.out_pc    = head.pc;
    assign fq.out_instr = head.instr;
    assign fq.count     = count;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (fq.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    // Storage survives a flush; only reset clears it.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < DEPTH; i++) storage[i] <= '0;
        end else if (push) begin
            storage[wr_ptr] <= '{pc: fq.in_pc, instr: fq.in_instr};
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a queue-based reference model checked every
// cycle, plus hand-computed literal checks along the test plan.
module tb_fetch_queue;
  import fetch_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  fetch_queue_if #(.AW(AW)) fq ();

  fetch_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .fq    (fq.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: a plain FIFO of entries
  fetch_entry_t model_q[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_q.delete();
    end else if (fq.flush) begin
      model_q.delete();
    end else begin
      automatic bit was_full  = (model_q.size() == DEPTH);
      automatic bit was_empty = (model_q.size() == 0);
      automatic bit do_push   = fq.in_valid && !was_full;
      automatic bit do_pop    = fq.out_ready && !was_empty;
      if (do_pop) void'(model_q.pop_front());
      if (do_push) model_q.push_back('{pc: fq.in_pc, instr: fq.in_instr});
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // compare process, away from the active edge
  always @(negedge clk) begin
    if (rst_n) begin
      check("m_in_ready",  64'(fq.in_ready),  64'(model_q.size() != DEPTH));
      check("m_out_valid", 64'(fq.out_valid), 64'(model_q.size() != 0));
      check("m_count",     64'(fq.count),     64'(model_q.size()));
      if (model_q.size() != 0) begin
        check("m_out_pc",    64'(fq.out_pc),    64'(model_q[0].pc));
        check("m_out_instr", 64'(fq.out_instr), 64'(model_q[0].instr));
      end
    end
  end

  // driver: present inputs for one cycle, return #1 after the edge
  task automatic cyc(input logic v, input logic [31:0] pc, input logic rdy, input logic fl);
    fq.in_valid  = v;
    fq.in_pc     = pc;
    fq.in_instr  = 32'hA500_0000 | pc;
    fq.out_ready = rdy;
    fq.flush     = fl;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ins(input logic [31:0] pc);
    return 32'hA500_0000 | pc;
  endfunction

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    fq.in_valid  = 1'b1;
    fq.in_pc     = 32'h0000_00FC;
    fq.in_instr  = 32'hDEAD_BEEF;
    fq.out_ready = 1'b0;
    fq.flush     = 1'b0;

    // 1. reset with in_valid held high
    repeat (3) @(posedge clk);
    #1;
    check("rst_count",     64'(fq.count),     64'd0);
    check("rst_out_valid", 64'(fq.out_valid), 64'd0);
    check("rst_in_ready",  64'(fq.in_ready),  64'd1);
    check("rst_out_pc",    64'(fq.out_pc),    64'd0);
    check("rst_out_instr", 64'(fq.out_instr), 64'd0);
    fq.in_valid = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    fq.in_instr = 32'h1111_1111;
    fq.in_pc    = 32'h0;
    fq.in_valid = 1'b1;
    @(posedge clk);
    #1;
    fq.in_valid = 1'b0;
    check("t1_out_valid", 64'(fq.out_valid), 64'd1);
    check("t1_out_pc",    64'(fq.out_pc),    64'd0);
    check("t1_out_instr", 64'(fq.out_instr), 64'h1111_1111);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    check("t1_drained", 64'(fq.count), 64'd0);

    // 2. fill, ignored fifth push, ordered drain
    for (int i = 0; i < 4; i++) cyc(1'b1, 32'(i * 4), 1'b0, 1'b0);
    check("t2_count_full", 64'(fq.count),    64'd4);
    check("t2_in_ready",   64'(fq.in_ready), 64'd0);
    cyc(1'b1, 32'h10, 1'b0, 1'b0);
    check("t2_fifth_ignored", 64'(fq.count), 64'd4);
    for (int i = 0; i < 4; i++) begin
      check("t2_drain_pc",    64'(fq.out_pc),    64'(i * 4));
      check("t2_drain_instr", 64'(fq.out_instr), 64'(ins(32'(i * 4))));
      cyc(1'b0, 32'h0, 1'b1, 1'b0);
    end
    check("t2_empty", 64'(fq.out_valid), 64'd0);

    // 3. streaming across pointer wraps
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 32'(i * 4), 1'b1, 1'b0);
      check("t3_count",  64'(fq.count),  64'd1);
      check("t3_out_pc", 64'(fq.out_pc), 64'(i * 4));
    end

    // 4. full plus pop: pop only, then push accepted
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'(32'h28 + i * 4), 1'b0, 1'b0);
    check("t4_full", 64'(fq.count), 64'd4);
    cyc(1'b1, 32'h34, 1'b1, 1'b0);
    check("t4_pop_only",   64'(fq.count),  64'd3);
    check("t4_head_after", 64'(fq.out_pc), 64'h28);
    cyc(1'b1, 32'h34, 1'b1, 1'b0);
    check("t4_push_pop", 64'(fq.count),  64'd3);
    check("t4_head",     64'(fq.out_pc), 64'h2C);

    // 5. flush with a concurrent in_valid
    cyc(1'b1, 32'h40, 1'b0, 1'b1);
    check("t5_count",     64'(fq.count),     64'd0);
    check("t5_out_valid", 64'(fq.out_valid), 64'd0);
    check("t5_in_ready",  64'(fq.in_ready),  64'd1);
    cyc(1'b1, 32'h80, 1'b0, 1'b0);
    check("t5_out_pc",    64'(fq.out_pc),    64'h80);
    check("t5_count_one", 64'(fq.count),     64'd1);

    // 6. async reset between edges
    cyc(1'b1, 32'h84, 1'b0, 1'b0);
    fq.in_valid = 1'b0;
    check("t6_pre_count", 64'(fq.count), 64'd2);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_count",     64'(fq.count),     64'd0);
    check("t6_async_out_valid", 64'(fq.out_valid), 64'd0);
    check("t6_async_in_ready",  64'(fq.in_ready),  64'd1);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc(1'b1, 32'h100, 1'b0, 1'b0);
    check("t6_recover_pc", 64'(fq.out_pc), 64'h100);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    check("t6_recover_empty", 64'(fq.out_valid), 64'd0);
    @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
